// File: rtl/act_feeder.sv
// act_feeder: streams activation words from SRAM to the downstream row
// buffer, one tile at a time.
//   clk_l, rst_n          : clock, async active-low reset
//   cfg_en/base/len/tiles : one-cycle job configuration (accepted in IDLE)
//   mem_rd_en/addr/data   : SRAM read port, data returns one cycle after en
//   actbuf_wr_req/vld/data: downstream handshake, registered output word
//   sblk_status           : rising edge = downstream finished a tile
//   busy, done            : job active / one-cycle completion pulse
module act_feeder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 10,
  parameter int TILE_W = 8
) (
  input  logic                clk_l,
  input  logic                rst_n,
  input  logic                cfg_en,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic [TILE_W-1:0]   cfg_tiles,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [2*DATA_W-1:0] mem_rd_data,
  input  logic                actbuf_wr_req,
  output logic                actbuf_wr_vld,
  output logic [2*DATA_W-1:0] actbuf_wr_data,
  input  logic                sblk_status,
  output logic                busy,
  output logic                done
);
  typedef enum logic [1:0] {IDLE, RUN, WAIT_BLK, FIN} state_t;

  state_t                         r_state, w_nxt;
  logic [ADDR_W-1:0]              r_addr;
  logic [LEN_W-1:0]               r_len, r_issued, r_sent;
  logic [TILE_W-1:0]              r_tiles, r_tile_cnt;
  logic [1:0][2*DATA_W-1:0]       r_fifo;
  logic                           r_wptr, r_rptr;
  logic [1:0]                     r_cnt;
  logic                           r_inflight;
  logic                           r_stat_q;
  logic                           r_vld;
  logic [2*DATA_W-1:0]            r_data;

  logic       w_pop, w_rd, w_rise;
  logic [1:0] w_occ;

  assign w_occ  = r_cnt + {1'b0, r_inflight};
  assign w_rise = sblk_status & ~r_stat_q;
  assign w_pop  = (r_state == RUN) && actbuf_wr_req && (r_cnt != 2'd0);
  // A pop at this edge frees a slot, so a read may be issued against it;
  // this keeps the stream gap-free while occupancy never exceeds two.
  assign w_rd   = (r_state == RUN) && (r_issued < r_len) &&
                  ((w_occ - {1'b0, w_pop}) < 2'd2);

  assign mem_rd_en      = w_rd;
  assign mem_rd_addr    = r_addr;
  assign actbuf_wr_vld  = r_vld;
  assign actbuf_wr_data = r_data;
  assign busy           = (r_state != IDLE);
  assign done           = (r_state == FIN);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:     if (cfg_en) w_nxt = (cfg_len == '0 || cfg_tiles == '0) ? FIN : RUN;
      RUN:      if (w_pop && ((r_sent + 1'b1) == r_len)) w_nxt = WAIT_BLK;
      WAIT_BLK: if (w_rise) w_nxt = ((r_tile_cnt + 1'b1) == r_tiles) ? FIN : RUN;
      FIN:      w_nxt = IDLE;
      default:  w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_tiles    <= '0;
      r_issued   <= '0;
      r_sent     <= '0;
      r_tile_cnt <= '0;
      r_fifo     <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
      r_stat_q   <= 1'b0;
      r_vld      <= 1'b0;
      r_data     <= '1;
    end else begin
      r_state    <= w_nxt;
      r_stat_q   <= sblk_status;
      r_inflight <= w_rd;
      r_vld      <= w_pop;
      r_data     <= w_pop ? r_fifo[r_rptr] : '1;
      r_cnt      <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
      if (r_inflight) begin
        r_fifo[r_wptr] <= mem_rd_data;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
        r_sent <= r_sent + 1'b1;
      end
      if (w_rd) begin
        r_addr   <= r_addr + 1'b1;
        r_issued <= r_issued + 1'b1;
      end
      case (r_state)
        IDLE: if (cfg_en) begin
          r_addr     <= cfg_base;
          r_len      <= cfg_len;
          r_tiles    <= cfg_tiles;
          r_issued   <= '0;
          r_sent     <= '0;
          r_tile_cnt <= '0;
        end
        // Next tile: per-tile counters restart, address keeps running.
        WAIT_BLK: if (w_rise) begin
          r_tile_cnt <= r_tile_cnt + 1'b1;
          r_issued   <= '0;
          r_sent     <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/act_feeder.md
ACT_FEEDER -- requirements
Module: act_feeder

Interface
REQ-001 Parameter DATA_W, default 16, width of one activation lane (two lanes per word).
REQ-002 Parameter ADDR_W, default 12, activation SRAM address width.
REQ-003 Parameter LEN_W, default 10, words-per-tile counter width.
REQ-004 Parameter TILE_W, default 8, tile counter width.
REQ-005 Port clk_l  input  1  sole clock; all logic on rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port cfg_en  input  1  one-cycle configuration strobe.
REQ-008 Port cfg_base  input  ADDR_W  first SRAM address.
REQ-009 Port cfg_len  input  LEN_W  words per tile.
REQ-010 Port cfg_tiles  input  TILE_W  number of tiles.
REQ-011 Port mem_rd_en  output  1  SRAM read strobe.
REQ-012 Port mem_rd_addr  output  ADDR_W  SRAM read address.
REQ-013 Port mem_rd_data  input  2*DATA_W  SRAM data, valid exactly 1 cycle after mem_rd_en.
REQ-014 Port actbuf_wr_req  input  1  downstream sblk_row ready-for-data request.
REQ-015 Port actbuf_wr_vld  output  1  activation word valid.
REQ-016 Port actbuf_wr_data  output  2*DATA_W  activation word.
REQ-017 Port sblk_status  input  1  downstream tile-complete status; rising edge marks tile done.
REQ-018 Port busy  output  1  high in any state except IDLE.
REQ-019 Port done  output  1  one-cycle pulse when all tiles are delivered and acknowledged.

Function
REQ-020 FSM states: IDLE, RUN, WAIT_BLK, FIN.
REQ-021 IDLE + cfg_en=1: latch cfg_base/cfg_len/cfg_tiles, clear counters, go RUN; cfg_en in other states is ignored.
REQ-022 IDLE + cfg_en=1 with cfg_len=0 or cfg_tiles=0: go FIN directly, no reads, no output words.
REQ-023 Buffering: 2-entry FIFO of 2*DATA_W words; occupancy = FIFO count + reads in flight, never above 2.
REQ-024 In RUN, mem_rd_en=1 when issued-in-tile < len and occupancy < 2; mem_rd_addr = base + total words issued since cfg_en, wrapping modulo 2^ADDR_W.
REQ-025 mem_rd_data is pushed into the FIFO on the cycle after mem_rd_en=1.
REQ-026 Output is registered: at an edge where actbuf_wr_req=1 and FIFO non-empty (RUN only), pop head; actbuf_wr_vld<=1, actbuf_wr_data<=head.
REQ-027 Otherwise actbuf_wr_vld<=0 and actbuf_wr_data<=all ones ({DATA_W{1}},{DATA_W{1}}).
REQ-028 Latency: first valid word no earlier than 2 cycles after RUN entry with req=1; vld at cycle n+1 only if req=1 at cycle n.
REQ-029 Push and pop in the same cycle are allowed; occupancy is unchanged.
REQ-030 Exactly cfg_len words are sent per tile; when the sent count reaches len, go WAIT_BLK; no reads are issued in WAIT_BLK.
REQ-031 sblk_status rising edge = sampled 1 while the previous-cycle sample was 0; edges outside WAIT_BLK are ignored.
REQ-032 WAIT_BLK + rising edge: increment the tile counter; if it equals tiles go FIN, else go RUN with the per-tile counters cleared and the address continuing.
REQ-033 FIN: done=1 for exactly one cycle, then IDLE.

Reset
REQ-034 rst_n low: state IDLE, FIFO and counters cleared, in-flight read discarded.
REQ-035 Outputs under reset: mem_rd_en=0, mem_rd_addr=0, actbuf_wr_vld=0, actbuf_wr_data=all ones, busy=0, done=0.
REQ-036 Reset mid-operation aborts immediately; no words are emitted until the next cfg_en.

Verification
REQ-037 base=0x010, len=4, tiles=1, req held 1, SRAM data=address -> vld words 0x010..0x013 on consecutive cycles; WAIT_BLK; status edge -> done pulse, IDLE.
REQ-038 len=27, tiles=1, req pattern 1 for 3 cycles, 0 for 5 cycles, repeating -> all 27 words in order, none dropped or duplicated; vld never 1 unless req=1 the previous cycle; data=0xFFFFFFFF whenever vld=0.
REQ-039 len=3, tiles=2, base=0xFFE -> addresses 0xFFE, 0xFFF, 0x000 in tile 0 (wrap), then 0x001..0x003 only after the status edge; status pulses during RUN are ignored.
REQ-040 cfg_tiles=0 -> done one cycle after cfg_en; mem_rd_en and vld stay 0.
REQ-041 rst_n low mid-tile with one word in flight -> next cycle vld=0, busy=0; after reset, a new cfg_en restarts at cfg_base.
REQ-042 cfg_en pulsed during RUN -> ignored; the original len/tiles complete unchanged.
